// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory request/response port between fetch and imem
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [INST_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC, single-outstanding imem fetch, 2-entry decode buffer
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c00_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    inst_fetch_if.master          imem,
    output logic                  out_valid,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_pred_taken,
    output logic [ADDR_WIDTH-1:0] out_pred_target
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;

    logic [INST_WIDTH-1:0] buf_inst [2];
    logic [ADDR_WIDTH-1:0] buf_pc   [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  req;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; redirect never blocks a returning response from closing out the wait
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem.rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        req  = 1'b0;
        push = 1'b0;
        case (state)
            S_REQ:   req  = rst_n & (count < 2'd2) & ~redirect_valid;
            S_WAIT:  push = imem.rvalid & ~redirect_valid;
            default: begin
                req  = 1'b0;
                push = 1'b0;
            end
        endcase
    end

    assign issue     = req & imem.gnt;
    assign imem.req  = req;
    assign imem.addr = fetch_pc;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & ~stall & ~redirect_valid;
    assign wr_ptr    = rd_ptr ^ count[0];

    // PC, in-flight PC and buffer occupancy; redirect wins over push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end

            if (issue) begin
                req_pc <= fetch_pc;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            if (redirect_valid) begin
                count <= 2'd0;
            end else if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end

            if (push) begin
                assert (count != 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem.rdata;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end

    assign out_inst        = out_valid ? buf_inst[rd_ptr] : '0;
    assign out_pc          = out_valid ? buf_pc[rd_ptr] : '0;
    assign out_pred_taken  = 1'b0;
    assign out_pred_target = out_pc + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed vector table plus randomized run against a stream-order model
module tb_inst_fetch;

    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;

    inst_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

    inst_fetch #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .RESET_PC  (RPC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem           (bus),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_pred_target(out_pred_target)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
    endfunction

    typedef struct {
        logic        rn;
        logic        redir;
        logic [31:0] rpc;
        logic        st;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic redir, input logic [31:0] rpc,
                                input logic st, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rn = rn; v.redir = redir; v.rpc = rpc; v.st = st; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t tbl[$];

    logic [31:0] exp_pc;
    logic [31:0] exp_grant;
    logic [31:0] pend_addr;
    logic [31:0] rpc_tmp;
    logic        outstanding;
    logic        expect_empty;
    logic        rv;
    logic        granted;
    int          lat;
    int          consumed;

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        bus.gnt = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0;

        // reset, streaming, backpressure
        tbl.push_back(mk(0,0,0,0,1,0,0,                        0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                        0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,RPC,          0,0));
        tbl.push_back(mk(1,0,0,0,1,1,mem_word(RPC),            0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,RPC+4,        1,RPC));
        tbl.push_back(mk(1,0,0,0,1,1,mem_word(RPC+4),          0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,RPC+8,        1,RPC+4));
        tbl.push_back(mk(1,0,0,1,1,1,mem_word(RPC+8),          0,0,            0,0));
        tbl.push_back(mk(1,0,0,1,1,0,0,                        1,RPC+12,       1,RPC+8));
        tbl.push_back(mk(1,0,0,1,1,1,mem_word(RPC+12),         0,0,            1,RPC+8));
        tbl.push_back(mk(1,0,0,1,1,0,0,                        0,0,            1,RPC+8));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        0,0,            1,RPC+8));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,RPC+16,       1,RPC+12));
        // stale response after redirect in WAIT
        tbl.push_back(mk(1,1,RPC+32'h100,0,1,0,0,              0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,1,32'hdeadbeef,             0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,RPC+32'h100,  0,0));
        tbl.push_back(mk(1,0,0,0,1,1,mem_word(RPC+32'h100),    0,0,            0,0));
        // redirect with a full buffer under stall
        tbl.push_back(mk(1,0,0,1,1,0,0,                        1,RPC+32'h104,  1,RPC+32'h100));
        tbl.push_back(mk(1,0,0,1,1,1,mem_word(RPC+32'h104),    0,0,            1,RPC+32'h100));
        tbl.push_back(mk(1,1,RPC+32'h200,1,1,0,0,              0,0,            1,RPC+32'h100));
        // slow grant, then redirect to the top of the address space
        tbl.push_back(mk(1,0,0,1,0,0,0,                        1,RPC+32'h200,  0,0));
        tbl.push_back(mk(1,0,0,1,0,0,0,                        1,RPC+32'h200,  0,0));
        tbl.push_back(mk(1,0,0,1,0,0,0,                        1,RPC+32'h200,  0,0));
        tbl.push_back(mk(1,1,32'hffff_fffc,0,1,0,0,            0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,32'hffff_fffc,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,mem_word(32'hffff_fffc),  0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,                        1,32'h0,        1,32'hffff_fffc));
        tbl.push_back(mk(1,0,0,0,1,1,mem_word(32'h0),          0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                        1,32'h4,        1,32'h0));
        // reset mid-operation; the abandoned response lands in REQ and is ignored
        tbl.push_back(mk(0,0,0,0,0,0,0,                        0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h1234_5678,            0,0,            0,0));
        tbl.push_back(mk(1,0,0,0,0,1,32'h1234_5678,            1,RPC,          0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                        1,RPC,          0,0));

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n          = tbl[i].rn;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            stall          = tbl[i].st;
            bus.gnt        = tbl[i].gnt;
            bus.rvalid     = tbl[i].rv;
            bus.rdata      = tbl[i].rdata;
            #1;
            check($sformatf("req[%0d]", i), 32'(bus.req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) check($sformatf("addr[%0d]", i), bus.addr, tbl[i].e_addr);
            check($sformatf("valid[%0d]", i), 32'(out_valid), 32'(tbl[i].e_valid));
            check($sformatf("pc[%0d]", i), out_pc, tbl[i].e_pc);
            check($sformatf("inst[%0d]", i), out_inst,
                  tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 32'h0);
            check($sformatf("target[%0d]", i), out_pred_target, tbl[i].e_pc + 32'd4);
            check($sformatf("taken[%0d]", i), 32'(out_pred_taken), 32'h0);
        end

        // Randomized run: delivered PCs must form the sequential stream from the last redirect
        exp_pc = RPC; exp_grant = RPC; outstanding = 1'b0; expect_empty = 1'b0;
        lat = 0; consumed = 0; pend_addr = '0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rv             = outstanding && (lat == 0);
            bus.rvalid     = rv;
            bus.rdata      = rv ? mem_word(pend_addr) : $urandom;
            bus.gnt        = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 24) == 0);
            rpc_tmp        = $urandom;
            if ($urandom_range(0, 1) == 0) rpc_tmp = 32'hffff_fff0 + ($urandom_range(0, 3) << 2);
            redirect_pc    = {rpc_tmp[31:2], 2'b00};
            rst_n          = !(i >= 2000 && i < 2002);
            #1;
            if (!rst_n) begin
                check("rnd_req_in_reset", 32'(bus.req), 32'h0);
                exp_pc = RPC; exp_grant = RPC; outstanding = 1'b0; expect_empty = 1'b1;
                continue;
            end
            if (expect_empty) check("rnd_empty_after_flush", 32'(out_valid), 32'h0);
            expect_empty = 1'b0;
            check("rnd_taken", 32'(out_pred_taken), 32'h0);
            if (out_valid) check("rnd_target", out_pred_target, out_pc + 32'd4);
            if (outstanding) check("rnd_one_in_flight", 32'(bus.req), 32'h0);
            if (redirect_valid) check("rnd_req_on_redirect", 32'(bus.req), 32'h0);
            if (out_valid && !stall && !redirect_valid) begin
                check("rnd_pc_order", out_pc, exp_pc);
                check("rnd_inst", out_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            granted = bus.req && bus.gnt;
            if (granted) begin
                check("rnd_grant_addr", bus.addr, exp_grant);
                exp_grant = exp_grant + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc; exp_grant = redirect_pc; expect_empty = 1'b1;
            end
            if (rv) outstanding = 1'b0;
            else if (outstanding) lat--;
            if (granted) begin
                outstanding = 1'b1;
                pend_addr   = bus.addr;
                lat         = $urandom_range(0, 3);
            end
        end
        check("rnd_progress", 32'(consumed > 200), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the in-order pipeline. It owns the program counter and issues word fetches to the instruction memory port, one request in flight at a time. Returned words go into a 2-entry buffer that feeds the decode stage. It applies a decode-stage redirect (predict-miss) by flushing the buffer, discarding any in-flight response and restarting at the corrected PC.

## Interface
- `RESET_PC`, default `32'h1c00_0000`: first fetch address after reset.
- `ADDR_WIDTH`, default 32: PC / memory address width.
- `INST_WIDTH`, default 32: instruction width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `redirect_valid` in 1: predict-miss from decode; flush and refetch.
- `redirect_pc` in ADDR_WIDTH: new fetch PC, valid with `redirect_valid`.
- `stall` in 1: decode not accepting this cycle.
- `imem_req` out 1: fetch request, level.
- `imem_addr` out ADDR_WIDTH: fetch address, word aligned.
- `imem_gnt` in 1: request accepted this cycle (sampled with `imem_req`).
- `imem_rvalid` in 1: response data valid, at least 1 cycle after grant.
- `imem_rdata` in INST_WIDTH: fetched instruction.
- `out_valid` out 1: buffer head valid (feeds decode `inst_valid`).
- `out_inst` out INST_WIDTH: head instruction.
- `out_pc` out ADDR_WIDTH: head PC.
- `out_pred_taken` out 1: predicted direction, constant 0 (static not-taken).
- `out_pred_target` out ADDR_WIDTH: predicted target, equals `out_pc + 4`.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `req_pc`: PC of the in-flight request.
  - FIFO: 2 entries of {inst, pc}, with a 2-bit `count`.
  - FSM state.
- FSM states:
  - REQ (no request outstanding).
    - `imem_req = (count < 2) & ~redirect_valid`, with `imem_addr = fetch_pc`.
    - On `imem_req & imem_gnt`: set `req_pc <= fetch_pc` and `fetch_pc <= fetch_pc + 4`, then go to WAIT.
  - WAIT (one request outstanding).
    - `imem_req = 0`.
    - On `imem_rvalid`: push {`imem_rdata`, `req_pc`} and go to REQ.
  - DROP (outstanding response is stale).
    - `imem_req = 0`.
    - On `imem_rvalid`: discard the data and go to REQ.
- Address handling while waiting for grant:
  - While `imem_req` is high and `imem_gnt` is low, `imem_addr` holds steady unless a redirect occurs.
  - The memory samples the address only at grant.
- Pop rule: the head is consumed when `out_valid & ~stall`.
- Push and pop in the same cycle are allowed; `count` is unchanged.
- Capacity: the issue condition `count < 2` with at most 1 outstanding guarantees a push never meets a full FIFO. Pushing into a full FIFO is an assertion failure.
- Redirect (`redirect_valid` = 1) has priority over every other event that cycle:
  - FIFO cleared (`count <= 0`) and any pop ignored.
  - `fetch_pc <= redirect_pc`.
  - State: WAIT goes to DROP. WAIT with a same-cycle `imem_rvalid` goes to REQ, and that response is discarded. REQ stays REQ; no grant is taken because `imem_req` is forced to 0. DROP stays DROP unless `imem_rvalid` arrives that cycle, in which case it goes to REQ.
- Simultaneous redirect and stall: the flush happens; stall is irrelevant.
- PC arithmetic: modulo 2^ADDR_WIDTH. `fetch_pc` wraps from `32'hffff_fffc` to 0 with no error.
- `redirect_pc[1:0]` must be 0. Misaligned values are passed through unchanged; alignment faults are not this block's concern.

## Timing
- Reset values (while `rst_n` = 0 at an edge):
  - `fetch_pc = RESET_PC`, state REQ, `count = 0`.
  - `imem_req = 0` while `rst_n` is low.
  - `out_valid = 0`, `out_inst = 0`, `out_pc = 0`, `out_pred_target = 4`.
- First request: in the first cycle with `rst_n` = 1.
- Reset asserted mid-operation (REQ/WAIT/DROP): the block returns to reset state at the next edge. Any later `imem_rvalid` for the abandoned request is ignored, because `imem_rvalid` is ignored in REQ.
- Latency, from grant to `out_valid`: rvalid latency + 1 (FIFO registered). With 1-cycle memory, a word granted in cycle t is visible at decode in cycle t+2.
- Throughput: one instruction per (memory latency + 1) cycles, because REQ is re-entered the cycle after rvalid.
- Redirect to first new request:
  - From REQ: 1 cycle, `imem_addr = redirect_pc` the cycle after redirect.
  - From WAIT/DROP: the cycle after the stale response returns.
- `out_valid` drops to 0 the cycle after a redirect.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 for 3 cycles, then release; `imem_gnt` = 1.
  - Response: during reset `imem_req` = 0 and `out_valid` = 0. In the first released cycle, `imem_req` = 1 and `imem_addr` = `32'h1c00_0000`.
- Streaming:
  - Stimulus: `imem_gnt` = 1, rvalid 1 cycle after grant, `stall` = 0.
  - Response: `out_pc` runs 0x1c000000, 0x1c000004, 0x1c000008, each for one cycle, one every 2 cycles. `out_inst` matches the memory model.
  - `out_pred_taken` = 0 and `out_pred_target` = `out_pc` + 4 throughout.
- Backpressure:
  - Stimulus: `stall` = 1 for 10 cycles.
  - Response: `count` reaches 2 and `imem_req` drops to 0. On release the 2 buffered PCs come out in order with no loss or duplicate, then fetching resumes.
- Stale response:
  - Stimulus: `redirect_valid` with `redirect_pc` = `32'h1c00_0100` the cycle after a grant; rvalid arrives 2 cycles later with 0xdeadbeef.
  - Response: 0xdeadbeef is never output, and the next `out_pc` is 0x1c000100.
- Redirect with full FIFO:
  - Stimulus: FIFO full, `stall` = 1, redirect to 0x1c000200.
  - Response: the next cycle `out_valid` = 0, and the next request address is 0x1c000200.
- Slow grant and wrap:
  - Stimulus: `imem_gnt` held low 3 cycles; redirect to 0xfffffffc.
  - Response: `imem_addr` stays stable across the 3 ungranted cycles. After the redirect, the fetches are 0xfffffffc then 0x00000000.
